// File: rtl/loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package loader_pkg;

  localparam int IMEM_DEPTH_DEF = 32768;
  localparam int ADDR_W_DEF     = 15;
  localparam int LEN_BYTES      = 4;
  localparam int SUM_BYTES      = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_DATA,
    S_SUM,
    S_DONE,
    S_ERROR
  } loader_state_e;

endpackage

// File: rtl/inst_mem_loader_byte_word_packer.sv
// Collects four bytes little-endian into a 32-bit word; the assembled word is
// presented combinationally in the same cycle the fourth byte is accepted.
module byte_word_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        byte_en,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        word_valid
);

  logic [1:0]  idx;
  logic [31:0] shreg;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      idx   <= 2'd0;
      shreg <= 32'd0;
    end else if (byte_en) begin
      idx   <= idx + 2'd1;
      shreg <= {byte_in, shreg[31:8]};
    end
  end

  // Newest byte lands on top, so the first byte ends up in bits 7:0.
  assign word       = {byte_in, shreg[31:8]};
  assign word_valid = byte_en && (idx == 2'd3);

endmodule

// File: rtl/inst_mem_loader.sv
// Framed program-image writer for the instruction RAM. Define
// IMEM_LOADER_CHECKSUM_EN to require a trailing 32-bit additive checksum.
// Handshake: a byte transfers on a rising edge where rx_valid && rx_ready.
module inst_mem_loader
  import loader_pkg::*;
#(
  parameter int IMEM_DEPTH = IMEM_DEPTH_DEF,
  parameter int ADDR_W     = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              core_hold,
  output logic              done,
  output logic              error,
  output loader_state_e     state
);

  localparam int CNT_W = ADDR_W + 1;

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam loader_state_e PAYLOAD_END = S_SUM;
  logic [31:0] sum_q;
`else
  localparam loader_state_e PAYLOAD_END = S_DONE;
`endif

  loader_state_e state_n;
  logic          busy;
  logic          load_req;
  logic          accept;
  logic [31:0]   word;
  logic          word_valid;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic [CNT_W-1:0] len_q;

  assign busy     = (state == S_LEN) || (state == S_DATA) || (state == S_SUM);
  assign load_req = start && ((state == S_IDLE) || (state == S_DONE) || (state == S_ERROR));
  assign accept   = rx_valid && busy;
  assign cnt_inc  = cnt + CNT_W'(1);

  assign rx_ready  = busy;
  assign core_hold = busy;
  assign done      = (state == S_DONE);
  assign error     = (state == S_ERROR);

  byte_word_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clear      (load_req),
    .byte_en    (accept),
    .byte_in    (rx_data),
    .word       (word),
    .word_valid (word_valid)
  );

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE, S_DONE, S_ERROR: if (start) state_n = S_LEN;
      S_LEN: begin
        if (word_valid) begin
          if (word == 32'd0)                  state_n = PAYLOAD_END;
          else if (word > 32'(IMEM_DEPTH))    state_n = S_ERROR;
          else                                state_n = S_DATA;
        end
      end
      S_DATA: if (word_valid && (cnt_inc == len_q)) state_n = PAYLOAD_END;
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_SUM: if (word_valid) state_n = (word == sum_q) ? S_DONE : S_ERROR;
`endif
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= 32'd0;
      cnt        <= '0;
      len_q      <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_q      <= 32'd0;
`endif
    end else begin
      state   <= state_n;
      imem_we <= 1'b0;
      if (load_req) begin
        cnt       <= '0;
        imem_addr <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        sum_q     <= 32'd0;
`endif
      end
      // Truncation is safe: oversize lengths never reach DATA.
      if (state == S_LEN && word_valid) len_q <= word[CNT_W-1:0];
      if (state == S_DATA && word_valid) begin
        imem_we    <= 1'b1;
        imem_addr  <= cnt[ADDR_W-1:0];
        imem_wdata <= word;
        cnt        <= cnt_inc;
`ifdef IMEM_LOADER_CHECKSUM_EN
        sum_q      <= sum_q + word;
`endif
      end
    end
  end

endmodule

// File: tb/tb_inst_mem_loader.sv
// Self-checking bench for inst_mem_loader; frames are built from a byte-level
// model of the image format and writes are compared against the source words.
module tb_inst_mem_loader;
  import loader_pkg::*;

  localparam int DEPTH = 32768;
  localparam int AW    = 15;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [7:0]    rx_data = 8'd0;
  logic          rx_valid = 1'b0;
  logic          rx_ready;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          core_hold;
  logic          done;
  logic          error;
  loader_state_e state;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0]   img_q[$];
  logic [AW-1:0] wa_q[$];
  logic [31:0]   wd_q[$];

  always #5 clk = ~clk;

  inst_mem_loader #(.IMEM_DEPTH(DEPTH), .ADDR_W(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .core_hold  (core_hold),
    .done       (done),
    .error      (error),
    .state      (state)
  );

  // Every cycle with the strobe high is logged, so a stuck strobe shows as extra writes.
  always @(negedge clk) begin
    if (imem_we) begin
      wa_q.push_back(imem_addr);
      wd_q.push_back(imem_wdata);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int t;
    if (gaps) begin
      repeat ($urandom_range(0, 3)) begin
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
        tick();
      end
    end
    rx_data  = b;
    rx_valid = 1'b1;
    t = 0;
    @(negedge clk);
    while (!rx_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!rx_ready) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_byte_timeout: rx_ready=%0b required 1", rx_ready);
    end
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic run_image(input string name, input logic [31:0] n, input bit gaps,
                           input bit bad_sum);
    logic [7:0]  frame[$];
    logic [31:0] sum;
    bit          exp_err;
    int          nw;
    sum     = 32'd0;
    exp_err = (n > 32'(DEPTH));
    nw      = exp_err ? 0 : int'(n);
    for (int i = 0; i < 4; i++) frame.push_back(n[8*i +: 8]);
    if (!exp_err) begin
      for (int w = 0; w < nw; w++) begin
        for (int b = 0; b < 4; b++) frame.push_back(img_q[w][8*b +: 8]);
        sum += img_q[w];
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      if (bad_sum) sum += 32'd1;
      exp_err = bad_sum;
      for (int b = 0; b < 4; b++) frame.push_back(sum[8*b +: 8]);
`endif
    end
    wa_q.delete();
    wd_q.delete();
    pulse_start();
    @(negedge clk);
    n_tests++;
    if (core_hold !== 1'b1 || done !== 1'b0 || error !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_after_start: hold/done/err=%b%b%b required 100", name, core_hold, done, error);
    end
    tick();
    foreach (frame[i]) send_byte(frame[i], gaps);
    @(negedge clk);
    n_tests++;
    if (done !== !exp_err || error !== exp_err) begin
      n_fail++;
      $display("FAIL %s_status: done=%b error=%b required done=%b error=%b", name, done, error, !exp_err, exp_err);
    end
    n_tests++;
    if (core_hold !== 1'b0 || rx_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_release: core_hold=%b rx_ready=%b required 0 0", name, core_hold, rx_ready);
    end
    repeat (2) @(negedge clk);
    n_tests++;
    if (wa_q.size() != nw) begin
      n_fail++;
      $display("FAIL %s_write_count: got %0d required %0d", name, wa_q.size(), nw);
    end
    for (int i = 0; i < nw && i < wa_q.size(); i++) begin
      n_tests++;
      if (wa_q[i] !== AW'(i) || wd_q[i] !== img_q[i]) begin
        n_fail++;
        $display("FAIL %s_write%0d: addr=%0d data=%h required addr=%0d data=%h", name, i, wa_q[i], wd_q[i], i, img_q[i]);
      end
    end
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    n_tests++;
    if (rx_ready !== 1'b0 || imem_we !== 1'b0 || core_hold !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: rx_ready=%b imem_we=%b core_hold=%b required 000", rx_ready, imem_we, core_hold);
    end
    n_tests++;
    if (imem_addr !== '0 || imem_wdata !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_bus: addr=%h wdata=%h required 0 0", imem_addr, imem_wdata);
    end
    n_tests++;
    if (done !== 1'b0 || error !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags: done=%b error=%b required 0 0", done, error);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_program();
    img_q = '{32'h0000_0013, 32'h0010_0093};
    run_image("program", 32'd2, 1'b0, 1'b0);
  endtask

  task automatic test_zero_len();
    img_q.delete();
    run_image("zero_len", 32'd0, 1'b0, 1'b0);
  endtask

  task automatic test_oversize();
    img_q.delete();
    run_image("oversize", 32'd32769, 1'b0, 1'b0);
    rx_valid = 1'b1;
    rx_data  = 8'hA5;
    repeat (3) begin
      @(negedge clk);
      n_tests++;
      if (rx_ready !== 1'b0 || error !== 1'b1) begin
        n_fail++;
        $display("FAIL oversize_idle: rx_ready=%b error=%b required 0 1", rx_ready, error);
      end
    end
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic test_max_len();
    logic [31:0] n;
    n = 32'(DEPTH);
    pulse_start();
    for (int i = 0; i < 4; i++) send_byte(n[8*i +: 8], 1'b0);
    @(negedge clk);
    n_tests++;
    if (rx_ready !== 1'b1 || error !== 1'b0 || core_hold !== 1'b1) begin
      n_fail++;
      $display("FAIL max_len_accept: rx_ready=%b error=%b hold=%b required 1 0 1", rx_ready, error, core_hold);
    end
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_random_gaps();
    int n;
    for (int r = 0; r < 4; r++) begin
      n = (r == 0) ? 3 : $urandom_range(1, 6);
      img_q.delete();
      for (int i = 0; i < n; i++) img_q.push_back($urandom);
      run_image("gaps", 32'(n), 1'b1, 1'b0);
    end
  endtask

  task automatic test_start_ignored();
    logic [31:0] w;
    w = $urandom;
    img_q = '{w};
    wa_q.delete();
    wd_q.delete();
    pulse_start();
    send_byte(8'h01, 1'b0);
    repeat (3) send_byte(8'h00, 1'b0);
    send_byte(w[7:0], 1'b0);
    send_byte(w[15:8], 1'b0);
    start = 1'b1;
    send_byte(w[23:16], 1'b0);
    start = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(w[31:24], 1'b0);
    for (int b = 0; b < 4; b++) send_byte(w[8*b +: 8], 1'b0);
`else
    send_byte(w[31:24], 1'b0);
`endif
    repeat (3) @(negedge clk);
    n_tests++;
    if (done !== 1'b1 || wa_q.size() != 1) begin
      n_fail++;
      $display("FAIL start_ignored: done=%b writes=%0d required 1 1", done, wa_q.size());
    end else begin
      n_tests++;
      if (wa_q[0] !== '0 || wd_q[0] !== w) begin
        n_fail++;
        $display("FAIL start_ignored_data: addr=%0d data=%h required 0 %h", wa_q[0], wd_q[0], w);
      end
    end
    tick();
  endtask

  task automatic test_reset_mid();
    wa_q.delete();
    wd_q.delete();
    pulse_start();
    send_byte(8'h02, 1'b0);
    repeat (3) send_byte(8'h00, 1'b0);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    rst = 1'b1;
    tick();
    @(negedge clk);
    n_tests++;
    if (rx_ready !== 1'b0 || core_hold !== 1'b0 || done !== 1'b0 || error !== 1'b0 ||
        imem_we !== 1'b0 || imem_addr !== '0 || imem_wdata !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_mid_outputs: rdy=%b hold=%b done=%b err=%b we=%b addr=%h wdata=%h required all 0",
               rx_ready, core_hold, done, error, imem_we, imem_addr, imem_wdata);
    end
    n_tests++;
    if (wa_q.size() != 0) begin
      n_fail++;
      $display("FAIL reset_mid_no_write: writes=%0d required 0", wa_q.size());
    end
    tick();
    rst = 1'b0;
    tick();
    img_q.delete();
    for (int i = 0; i < 3; i++) img_q.push_back($urandom);
    run_image("after_reset", 32'd3, 1'b1, 1'b0);
  endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    img_q = '{32'h1, 32'h2};
    run_image("sum_ok", 32'd2, 1'b0, 1'b0);
    run_image("sum_bad", 32'd2, 1'b0, 1'b1);
  endtask
`endif

  initial begin
    test_reset();
    test_program();
    test_zero_len();
    test_oversize();
    test_max_len();
    test_random_gaps();
    test_start_ignored();
    test_reset_mid();
`ifdef IMEM_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
